// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses, cause codes, mstatus fields, FSM states and trap helpers
package trap_ctrl_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [3:0] EXC_ILLEGAL = 4'd2;
    localparam logic [3:0] EXC_EBREAK  = 4'd3;
    localparam logic [3:0] EXC_ECALL   = 4'd11;
    localparam logic [3:0] IRQ_SW      = 4'd3;
    localparam logic [3:0] IRQ_TIMER   = 4'd7;
    localparam logic [3:0] IRQ_EXT     = 4'd11;
    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;
    typedef enum logic [2:0] {IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, T_REDIR, R_MSTATUS, R_REDIR} state_t;
    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MS_MPIE] = m[MS_MIE];
        r[MS_MIE] = 1'b0;
        r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        return r;
    endfunction
    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MS_MIE] = m[MS_MPIE];
        r[MS_MPIE] = 1'b1;
        r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        return r;
    endfunction
    function automatic logic [31:0] trap_vector(input logic [31:0] mtvec, input logic [31:0] cause);
        return {mtvec[31:2], 2'b00} + ((mtvec[1:0] == 2'b01 && cause[31]) ? {26'b0, cause[3:0], 2'b00} : 32'b0);
    endfunction
endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: EX/interrupt/CSR inputs and CSR-write/flush/redirect outputs of the trap sequencer
interface trap_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_exc;
    logic [3:0]  ex_exc_code;
    logic        ex_mret;
    logic        irq_ext;
    logic        irq_sw;
    logic        irq_timer;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        trap_csr_we;
    logic [11:0] trap_csr_waddr;
    logic [31:0] trap_csr_wdata;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    modport master (
        output ex_valid, ex_pc, ex_exc, ex_exc_code, ex_mret, irq_ext, irq_sw, irq_timer,
               csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
        input  trap_csr_we, trap_csr_waddr, trap_csr_wdata, flush, stall, redirect_valid, redirect_pc
    );
    modport slave (
        input  ex_valid, ex_pc, ex_exc, ex_exc_code, ex_mret, irq_ext, irq_sw, irq_timer,
               csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
        output trap_csr_we, trap_csr_waddr, trap_csr_wdata, flush, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl_irq_prio_enc.sv
// irq_prio_enc: enabled-interrupt detect and priority encode, ext > sw > timer
module irq_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic [2:0]  mip,
    input  logic [31:0] mie,
    input  logic        gie,
    output logic        pend,
    output logic [3:0]  code
);
    logic [2:0] hit;
    logic       unused_mie;
    assign hit = mip & {mie[IRQ_EXT], mie[IRQ_SW], mie[IRQ_TIMER]} & {3{gie}};
    assign pend = |hit;
    assign code = hit[2] ? IRQ_EXT : hit[1] ? IRQ_SW : IRQ_TIMER;
    assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/MRET sequencer writing mepc, mcause, mstatus then redirecting fetch
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    trap_ctrl_if.slave tc
);
    state_t      state;
    logic        irq_pend;
    logic [3:0]  irq_code;
    logic        acc;
    logic        is_irq;
    logic        is_mret;
    logic [3:0]  code;
    logic [31:0] cause_q;
    logic [31:0] mstatus_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    irq_prio_enc u_enc (
        .mip ({tc.irq_ext, tc.irq_sw, tc.irq_timer}),
        .mie (tc.csr_mie),
        .gie (tc.csr_mstatus[MS_MIE]),
        .pend(irq_pend),
        .code(irq_code)
    );
    assign acc = state == IDLE && tc.ex_valid && (tc.ex_exc || irq_pend || tc.ex_mret);
    assign is_irq = !tc.ex_exc && irq_pend;
    assign is_mret = !tc.ex_exc && !irq_pend;
    assign code = tc.ex_exc ? tc.ex_exc_code : irq_code;
    assign tc.flush = rst_n && acc;
    // Outputs are registered on entry to each state so they line up with that state's cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            tc.trap_csr_we <= 1'b0;
            tc.trap_csr_waddr <= '0;
            tc.trap_csr_wdata <= '0;
            tc.stall <= 1'b0;
            tc.redirect_valid <= 1'b0;
            tc.redirect_pc <= '0;
            cause_q <= '0;
            mstatus_q <= '0;
            mtvec_q <= '0;
            mepc_q <= '0;
        end else begin
            tc.trap_csr_we <= 1'b0;
            tc.trap_csr_waddr <= '0;
            tc.trap_csr_wdata <= '0;
            tc.redirect_valid <= 1'b0;
            tc.redirect_pc <= '0;
            tc.stall <= 1'b1;
            case (state)
                IDLE: begin
                    if (acc) begin
                        cause_q <= {is_irq, 27'b0, code};
                        mstatus_q <= tc.csr_mstatus;
                        mtvec_q <= tc.csr_mtvec;
                        mepc_q <= tc.csr_mepc;
                        tc.trap_csr_we <= 1'b1;
                        state <= is_mret ? R_MSTATUS : T_MEPC;
                        tc.trap_csr_waddr <= is_mret ? CSR_MSTATUS : CSR_MEPC;
                        tc.trap_csr_wdata <= is_mret ? mret_mstatus(tc.csr_mstatus) : tc.ex_pc & ~32'h3;
                    end else begin
                        tc.stall <= 1'b0;
                    end
                end
                T_MEPC: begin
                    state <= T_MCAUSE;
                    tc.trap_csr_we <= 1'b1;
                    tc.trap_csr_waddr <= CSR_MCAUSE;
                    tc.trap_csr_wdata <= cause_q;
                end
                T_MCAUSE: begin
                    state <= T_MSTATUS;
                    tc.trap_csr_we <= 1'b1;
                    tc.trap_csr_waddr <= CSR_MSTATUS;
                    tc.trap_csr_wdata <= trap_mstatus(mstatus_q);
                end
                T_MSTATUS: begin
                    state <= T_REDIR;
                    tc.redirect_valid <= 1'b1;
                    tc.redirect_pc <= trap_vector(mtvec_q, cause_q);
                end
                R_MSTATUS: begin
                    state <= R_REDIR;
                    tc.redirect_valid <= 1'b1;
                    tc.redirect_pc <= mepc_q;
                end
                default: begin
                    state <= IDLE;
                    tc.stall <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed-vector bench for trap_ctrl with hand-computed expectations
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    trap_ctrl_if tc ();
    trap_ctrl dut (.clk(clk), .rst_n(rst_n), .tc(tc));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic expect_outs(input string tag, input logic we, input logic [11:0] wa, input logic [31:0] wd,
                               input logic fl, input logic st, input logic rv, input logic [31:0] rp);
        check({tag, ".we"}, 32'(tc.trap_csr_we), 32'(we));
        check({tag, ".waddr"}, 32'(tc.trap_csr_waddr), 32'(wa));
        check({tag, ".wdata"}, tc.trap_csr_wdata, wd);
        check({tag, ".flush"}, 32'(tc.flush), 32'(fl));
        check({tag, ".stall"}, 32'(tc.stall), 32'(st));
        check({tag, ".rv"}, 32'(tc.redirect_valid), 32'(rv));
        check({tag, ".rpc"}, tc.redirect_pc, rp);
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_ex();
        tc.ex_valid = 1'b0;
        tc.ex_exc = 1'b0;
        tc.ex_mret = 1'b0;
        tc.ex_exc_code = 4'd0;
    endtask
    task automatic trap_seq(input string tag, input logic [31:0] mepc, input logic [31:0] cause,
                            input logic [31:0] ms, input logic [31:0] rpc);
        #1 expect_outs({tag, ".T0"}, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        clear_ex();
        #1 expect_outs({tag, ".T1"}, 1'b1, 12'h341, mepc, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        #1 expect_outs({tag, ".T2"}, 1'b1, 12'h342, cause, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        #1 expect_outs({tag, ".T3"}, 1'b1, 12'h300, ms, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        #1 expect_outs({tag, ".T4"}, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1, 1'b1, rpc);
        cyc();
        #1 expect_outs({tag, ".T5"}, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask
    initial begin
        clear_ex();
        tc.ex_pc = 32'h0;
        tc.irq_ext = 1'b0;
        tc.irq_sw = 1'b0;
        tc.irq_timer = 1'b0;
        tc.csr_mstatus = 32'h0;
        tc.csr_mie = 32'h0;
        tc.csr_mtvec = 32'h0;
        tc.csr_mepc = 32'h0;
        cyc();
        cyc();
        tc.ex_valid = 1'b1;
        tc.ex_exc = 1'b1;
        tc.ex_exc_code = 4'd11;
        #1 expect_outs("rst", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        rst_n = 1'b1;
        clear_ex();
        #1 expect_outs("post_rst", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        // ecall, direct mtvec; CSR inputs change after accept to prove they were latched
        cyc();
        tc.ex_valid = 1'b1;
        tc.ex_exc = 1'b1;
        tc.ex_exc_code = 4'd11;
        tc.ex_pc = 32'h100;
        tc.csr_mstatus = 32'h8;
        tc.csr_mtvec = 32'h80;
        #1 expect_outs("ecall.T0", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        clear_ex();
        tc.csr_mstatus = 32'h0;
        tc.csr_mtvec = 32'hDEAD_0000;
        #1 expect_outs("ecall.T1", 1'b1, 12'h341, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        tc.ex_valid = 1'b1;
        tc.ex_exc = 1'b1;
        #1 expect_outs("ecall.T2", 1'b1, 12'h342, 32'h0000_000B, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        clear_ex();
        #1 expect_outs("ecall.T3", 1'b1, 12'h300, 32'h1880, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        #1 expect_outs("ecall.T4", 1'b0, 12'h000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80);
        cyc();
        #1 expect_outs("ecall.T5", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        // vectored timer interrupt, line held high throughout the sequence
        cyc();
        tc.csr_mtvec = 32'h201;
        tc.csr_mstatus = 32'h8;
        tc.csr_mie = 32'h80;
        tc.irq_timer = 1'b1;
        tc.ex_valid = 1'b1;
        tc.ex_pc = 32'h42;
        trap_seq("timer", 32'h40, 32'h8000_0007, 32'h1880, 32'h21C);
        tc.irq_timer = 1'b0;
        // illegal exception beats a simultaneous external interrupt
        cyc();
        tc.csr_mie = 32'h888;
        tc.irq_ext = 1'b1;
        tc.ex_valid = 1'b1;
        tc.ex_exc = 1'b1;
        tc.ex_exc_code = 4'd2;
        tc.ex_pc = 32'h30;
        trap_seq("exc_irq", 32'h30, 32'h0000_0002, 32'h1880, 32'h200);
        cyc();
        #1 expect_outs("no_valid", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        tc.irq_sw = 1'b1;
        tc.irq_timer = 1'b1;
        tc.ex_valid = 1'b1;
        tc.ex_pc = 32'h44;
        trap_seq("ext_prio", 32'h44, 32'h8000_000B, 32'h1880, 32'h22C);
        tc.irq_ext = 1'b0;
        // sw beats timer, direct mtvec gets no offset
        cyc();
        tc.csr_mtvec = 32'h80;
        tc.ex_valid = 1'b1;
        tc.ex_pc = 32'h50;
        trap_seq("sw_prio", 32'h50, 32'h8000_0003, 32'h1880, 32'h80);
        tc.irq_sw = 1'b0;
        tc.irq_timer = 1'b0;
        // ebreak together with mret: exception path, MIE already 0
        cyc();
        tc.csr_mstatus = 32'h1880;
        tc.ex_valid = 1'b1;
        tc.ex_exc = 1'b1;
        tc.ex_mret = 1'b1;
        tc.ex_exc_code = 4'd3;
        tc.ex_pc = 32'h10;
        trap_seq("exc_mret", 32'h10, 32'h0000_0003, 32'h1800, 32'h80);
        // mret
        cyc();
        tc.csr_mstatus = 32'h80;
        tc.csr_mepc = 32'h104;
        tc.ex_valid = 1'b1;
        tc.ex_mret = 1'b1;
        tc.ex_pc = 32'h300;
        #1 expect_outs("mret.T0", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        clear_ex();
        tc.csr_mepc = 32'h0;
        #1 expect_outs("mret.T1", 1'b1, 12'h300, 32'h1888, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        #1 expect_outs("mret.T2", 1'b0, 12'h000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104);
        cyc();
        #1 expect_outs("mret.T3", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        // masked software interrupt: global MIE off, then mie bit off
        tc.csr_mstatus = 32'h0;
        tc.csr_mie = 32'h8;
        tc.irq_sw = 1'b1;
        tc.ex_valid = 1'b1;
        #1 expect_outs("mask_gie", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        tc.csr_mstatus = 32'h8;
        tc.csr_mie = 32'h80;
        #1 expect_outs("mask_mie.a", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        clear_ex();
        tc.irq_sw = 1'b0;
        #1 expect_outs("mask_mie.b", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        // reset during the mcause write cancels the rest of the trap
        cyc();
        tc.ex_valid = 1'b1;
        tc.ex_exc = 1'b1;
        tc.ex_exc_code = 4'd11;
        tc.ex_pc = 32'h200;
        #1 expect_outs("rstmid.T0", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        clear_ex();
        #1 expect_outs("rstmid.T1", 1'b1, 12'h341, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        rst_n = 1'b0;
        #1 expect_outs("rstmid.T2", 1'b1, 12'h342, 32'h0000_000B, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        rst_n = 1'b1;
        #1 expect_outs("rstmid.T3", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        #1 expect_outs("rstmid.T4", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        #1 expect_outs("rstmid.T5", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
